// File: rtl/des_round_engine.sv
// des_round_engine -- iterative DES round datapath with the key schedule.
// Runs one Feistel round per clock: 16 rounds after a load edge, then a
// one-cycle DONE with the pre-output block R16||L16 on data_out. The f-function
// (E, S-boxes, P) is external and closes combinationally through f_result.
// Bit numbering follows FIPS 46-3: bit 1 is the MSB, held at index [N].
// Optional feature: define DES_ROUND_DECRYPT_EN to add the decrypt input,
// which walks the key schedule backwards (K16..K1).
module des_round_engine (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [64:1]  data_in,
  input  logic [64:1]  key_in,
`ifdef DES_ROUND_DECRYPT_EN
  input  logic         decrypt,
`endif
  input  logic [32:1]  f_result,
  output logic [32:1]  right_out,
  output logic [48:1]  subkey,
  output logic [4:1]   round,
  output logic         busy,
  output logic         done,
  output logic [64:1]  data_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // PC-1: entry i names the key bit that becomes C||D bit i+1.
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry i names the C||D bit that becomes subkey bit i+1.
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Pure bit selection; constant indices reduce to wiring.
  function automatic logic [56:1] pc1(input logic [64:1] k);
    logic [56:1] o;
    for (int i = 0; i < 56; i++) o[56-i] = k[65-PC1_T[i]];
    return o;
  endfunction

  function automatic logic [48:1] pc2(input logic [56:1] cd);
    logic [48:1] o;
    for (int i = 0; i < 48; i++) o[48-i] = cd[57-PC2_T[i]];
    return o;
  endfunction

  // Rotation count for DES round n (1..16).
  function automatic logic [1:0] shift_amt(input logic [4:0] n);
    return (n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16) ? 2'd1 : 2'd2;
  endfunction

  // Left rotation by 1 or 2; bit 1 (MSB) wraps to bit 28 (LSB).
  function automatic logic [28:1] rol28(input logic [28:1] x, input logic [1:0] amt);
    return (amt == 2'd1) ? {x[27:1], x[28]} : {x[26:1], x[28:27]};
  endfunction

  function automatic logic [28:1] ror28(input logic [28:1] x, input logic [1:0] amt);
    return (amt == 2'd1) ? {x[1], x[28:2]} : {x[2:1], x[28:3]};
  endfunction

  state_t       state_q, state_d;
  logic [32:1]  l_q, r_q;
  logic [28:1]  c_q, d_q;
  logic [4:1]   round_q;
  logic [64:1]  dout_q;
  logic         load, last;
  logic         dec_q, dec_load;
  logic [56:1]  cd_pc1;
  logic [28:1]  c_load, d_load, c_step, d_step;
  logic [1:0]   amt_enc, amt_dec;

`ifdef DES_ROUND_DECRYPT_EN
  assign dec_load = decrypt;

  // Direction of the key schedule, captured with start and held for the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    dec_q <= 1'b0;
    else if (load) dec_q <= decrypt;
  end
`else
  assign dec_load = 1'b0;
  assign dec_q    = 1'b0;
`endif

  // State sequencing: IDLE -> RUN on start, RUN -> DONE after round 16, DONE -> IDLE.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    state_d = state_q;
    load    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        load    = 1'b1;
      end
      RUN: if (round_q == 4'd15) begin
        state_d = DONE;
        last    = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Key schedule next values: the load value (K1 or K16 ready) and the per-round step.
  always_comb begin
    cd_pc1  = pc1(key_in);
    amt_enc = shift_amt({1'b0, round_q} + 5'd2);
    amt_dec = shift_amt(5'd16 - {1'b0, round_q});
    if (dec_load) begin
      // Total rotation over 16 rounds is 28, so C0D0 already equals C16D16.
      c_load = cd_pc1[56:29];
      d_load = cd_pc1[28:1];
    end else begin
      c_load = rol28(cd_pc1[56:29], 2'd1);
      d_load = rol28(cd_pc1[28:1], 2'd1);
    end
    if (round_q == 4'd15) begin
      c_step = c_q;
      d_step = d_q;
    end else if (dec_q) begin
      c_step = ror28(c_q, amt_dec);
      d_step = ror28(d_q, amt_dec);
    end else begin
      c_step = rol28(c_q, amt_enc);
      d_step = rol28(d_q, amt_enc);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Round datapath: load on start, one Feistel round per RUN edge, capture on the last.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values (l_q and r_q swap correctly).
    if (!rst_n) begin
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dout_q  <= '0;
    end else if (load) begin
      l_q     <= data_in[64:33];
      r_q     <= data_in[32:1];
      c_q     <= c_load;
      d_q     <= d_load;
      round_q <= '0;
    end else if (state_q == RUN) begin
      l_q     <= r_q;
      r_q     <= l_q ^ f_result;
      c_q     <= c_step;
      d_q     <= d_step;
      round_q <= round_q + 4'd1;  // wraps 15 -> 0 on the last edge
      if (last) dout_q <= {l_q ^ f_result, r_q};
    end
  end

  assign right_out = r_q;
  assign subkey    = pc2({c_q, d_q});
  assign round     = (state_q == RUN) ? round_q : 4'd0;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign data_out  = dout_q;

endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine -- directed known-answer bench for des_round_engine.
// Supplies the f-function, IP and FP from its own DES model and compares
// against published DES vectors. Define DES_ROUND_DECRYPT_EN for the
// decryption vectors.
module tb_des_round_engine;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
  };
  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
  };
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };
  // S-boxes, 64 nibbles each in row-major order (row = b1b6, column = b2..b5).
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT2  = 64'h8787878787878787;
  localparam logic [63:0] CT2  = 64'h0000000000000000;
  localparam logic [47:0] K1_OF_KEY1  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_OF_KEY1 = 48'hCB3D8B0E17F5;

  logic        clk, rst_n, start, decrypt;
  logic [63:0] data_in, key_in, data_out;
  logic [31:0] f_result, right_out;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  des_round_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .key_in    (key_in),
`ifdef DES_ROUND_DECRYPT_EN
    .decrypt   (decrypt),
`endif
    .f_result  (f_result),
    .right_out (right_out),
    .subkey    (subkey),
    .round     (round),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
    return o;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
    return o;
  endfunction

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [47:0]  x;
    logic [31:0]  s, o;
    logic [5:0]   six;
    logic [255:0] sb;
    int           idx;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      idx = {26'd0, six[5], six[0], six[4:1]};
      sb  = SBOX[b];
      s[31-4*b -: 4] = sb[255-4*idx -: 4];
    end
    for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
    return o;
  endfunction

  // External f-function closing the round loop combinationally.
  always_comb f_result = f_model(right_out, subkey);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Launch one block and follow it to done. lat counts rising edges from the
  // start-sampling edge to the first cycle with done high. restart_round >= 0
  // re-pulses start (with scrambled inputs) at that round.
  task automatic run_op(input logic [63:0] blk, input logic [63:0] key, input logic dec,
                        input int restart_round, output logic [63:0] result,
                        output int lat, output logic [47:0] k_first, output logic [47:0] k_last);
    k_first = '0;
    k_last  = '0;
    @(negedge clk);
    data_in = ip(blk);
    key_in  = key;
    decrypt = dec;
    start   = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 40) begin
      if (busy && int'(round) == restart_round) begin
        start   = 1'b1;
        data_in = ~data_in;
        key_in  = ~key_in;
      end else begin
        start = 1'b0;
      end
      if (busy && round == 4'd0)  k_first = subkey;
      if (busy && round == 4'd15) k_last  = subkey;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start  = 1'b0;
    result = fp(data_out);
  endtask

  logic [63:0] res, held;
  logic [47:0] kf, kl;
  int          lat, waited;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    decrypt = 1'b0;
    data_in = '0;
    key_in  = '0;
    #1;
    check("reset_busy",     {63'd0, busy},      64'd0);
    check("reset_done",     {63'd0, done},      64'd0);
    check("reset_data_out", data_out,           64'd0);
    check("reset_round",    {60'd0, round},     64'd0);
    check("reset_right",    {32'd0, right_out}, 64'd0);
    check("reset_subkey",   {16'd0, subkey},    64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Known-answer encryption, key schedule endpoints and latency.
    run_op(PT1, KEY1, 1'b0, -1, res, lat, kf, kl);
    check("enc1_result",  res,           CT1);
    check("enc1_latency", 64'(lat),      64'd17);
    check("enc1_k1",      {16'd0, kf},   {16'd0, K1_OF_KEY1});
    check("enc1_k16",     {16'd0, kl},   {16'd0, K16_OF_KEY1});
    check("enc1_busy_in_done",  {63'd0, busy},  64'd0);
    check("enc1_round_in_done", {60'd0, round}, 64'd0);

    // start during DONE is ignored; done is a single-cycle pulse; output holds.
    held    = data_out;
    start   = 1'b1;
    data_in = ~data_in;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored", {63'd0, busy}, 64'd0);
    check("done_one_cycle",     {63'd0, done}, 64'd0);
    check("data_out_held",      data_out,      held);
    @(posedge clk);
    @(negedge clk);
    check("idle_still_idle",    {63'd0, busy}, 64'd0);

    // Spurious start at round 5 must not disturb the running block.
    run_op(PT1, KEY1, 1'b0, 5, res, lat, kf, kl);
    check("restart_result",  res,      CT1);
    check("restart_latency", 64'(lat), 64'd17);

    // Asynchronous reset at round 8 abandons the block immediately.
    @(negedge clk);
    data_in = ip(PT1);
    key_in  = KEY1;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    waited = 0;
    while (!(busy && round == 4'd8) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("reach_round8", {63'd0, busy && round == 4'd8}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_busy",     {63'd0, busy},  64'd0);
    check("midrun_reset_data_out", data_out,       64'd0);
    check("midrun_reset_round",    {60'd0, round}, 64'd0);
    check("midrun_reset_done",     {63'd0, done},  64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // First edge after release accepts start; second known-answer vector.
    run_op(PT2, KEY2, 1'b0, -1, res, lat, kf, kl);
    check("enc2_result",  res,      CT2);
    check("enc2_latency", 64'(lat), 64'd17);
    run_op(PT1, KEY1, 1'b0, -1, res, lat, kf, kl);
    check("enc1_after_reset", res, CT1);

`ifdef DES_ROUND_DECRYPT_EN
    run_op(CT1, KEY1, 1'b1, -1, res, lat, kf, kl);
    check("dec1_result",  res,          PT1);
    check("dec1_first_k", {16'd0, kf},  {16'd0, K16_OF_KEY1});
    check("dec1_last_k",  {16'd0, kl},  {16'd0, K1_OF_KEY1});
    check("dec1_latency", 64'(lat),     64'd17);
    run_op(CT2, KEY2, 1'b1, -1, res, lat, kf, kl);
    check("dec2_result",  res,          PT2);
    run_op(PT1, KEY1, 1'b0, -1, res, lat, kf, kl);
    check("enc_after_dec", res,         CT1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/des_round_engine.md
DES_ROUND_ENGINE -- requirements
Module: des_round_engine

Interface
REQ-001 The block SHALL have clock port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have reset port rst_n, input, 1 bit: the reset is asynchronous and active-low.
REQ-003 start, input, 1 bit: single-cycle request to begin a block operation; sampled only in IDLE.
REQ-004 data_in, input, [64:1]: post-IP block; [64:33] = L0, [32:1] = R0.
REQ-005 key_in, input, [64:1]: 64-bit DES key including parity bits; FIPS 46-3 bit 1 = key_in[64]; sampled with start.
REQ-006 f_result, input, [32:1]: external f-function output P(S(E(right_out) ^ subkey)); combinational path, valid in the same cycle.
REQ-007 right_out, output, [32:1]: current R register; drives the f-function.
REQ-008 subkey, output, [48:1]: PC-2 of the current C||D; the round key for the current round.
REQ-009 round, output, [4:1]: current round index minus 1 (0..15); 0 when not RUN.
REQ-010 busy, output, 1 bit: high in RUN.
REQ-011 done, output, 1 bit: one-cycle pulse when data_out becomes valid.
REQ-012 data_out, output, [64:1]: pre-output block R16||L16; FP is applied downstream.

Function
REQ-013 State machine: IDLE -> RUN on start; RUN -> DONE after the 16th round edge; DONE -> IDLE unconditionally after one cycle.
REQ-014 On the start edge: L <= data_in[64:33], R <= data_in[32:1], C||D <= PC-1(key_in) left-rotated by shift(1), round <= 0.
REQ-015 In RUN, each edge: L <= R; R <= L ^ f_result; C and D each rotate left by shift(round+2) when round < 15; round increments.
REQ-016 Shift schedule: 1 bit for rounds 1, 2, 9 and 16; 2 bits for all other rounds; C and D are 28-bit registers rotated independently.
REQ-017 PC-1 and PC-2 SHALL be the FIPS 46-3 tables implemented as pure wiring.
REQ-018 On the 16th round edge: data_out <= {R_new, L_new}, i.e. the final swap; state <= DONE.
REQ-019 done SHALL be high only in DONE, exactly 17 cycles after the start edge; data_out SHALL hold its value until the next DONE.
REQ-020 start while in RUN or DONE SHALL be ignored, with no effect on state, registers or outputs.
REQ-021 In IDLE and DONE, right_out and subkey SHALL reflect the held registers; no register changes except on the start edge.

Reset
REQ-022 On rst_n low: state = IDLE; L, R, C, D, round and data_out = 0; busy = 0; done = 0; this takes effect immediately, including mid-RUN, where the operation is abandoned.
REQ-023 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-024 Macro DES_ROUND_DECRYPT_EN: when defined, the block SHALL add an input port decrypt, 1 bit, sampled with start.
REQ-025 With the macro and decrypt=1: C||D <= PC-1(key_in) unrotated at load, giving K16 first; each RUN edge right-rotates C and D by shift(16-round), producing keys K16..K1.
REQ-026 Without the macro, or with decrypt=0: encryption-only behaviour per REQ-014..REQ-016; no decrypt port exists.

Verification
REQ-027 key_in=133457799BBCDFF1, start -> subkey=1B02EFFC7072 in the first RUN cycle, and subkey=CB3D8B0E17F5 at round=15.
REQ-028 With a bench f-function, IP and FP models: plaintext 0123456789ABCDEF, key 133457799BBCDFF1 -> FP(data_out)=85E813540F0AB405; done fires 17 cycles after start.
REQ-029 start pulsed again at round=5 -> ignored; the result and timing are identical to REQ-028.
REQ-030 rst_n low at round=8 -> busy=0 and data_out=0 immediately; a new start after release gives the correct result.
REQ-031 With DES_ROUND_DECRYPT_EN: decrypt=1, ciphertext 85E813540F0AB405 (IP applied), same key -> FP(data_out)=0123456789ABCDEF; the first subkey is CB3D8B0E17F5.
